shift_seq: RTL and testbench
============================

Name: shift_seq

Overview:
Multi-cycle shift sequencer for the multicycle datapath variant. It accepts one shift request (sh, shamt5, operand) through a start/ready handshake. It performs the shift iteratively, at most STEP bit positions per cycle, and returns a registered result with a one-cycle done pulse. Encoding matches the shifter's: sh 00 LSL, 01 LSR, 10 ASR, 11 ROR; shamt5 = Instr[11:7]; bypass = pass-through.

Parameters:
WIDTH, 32, operand/result width; fixed at 32 for ISA use, shamt is 5 bits.
STEP, 4, maximum bit positions shifted per cycle; power of two, 1..16.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request valid; accepted only when ready=1.
ready  output  1  high in IDLE only.
bypass  input  1  sampled at accept; 1 = result equals din unshifted.
sh  input  2  shift type, sampled at accept.
shamt  input  5  shift amount 0..31, sampled at accept.
din  input  WIDTH  operand, sampled at accept.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse; result valid and final.
result  output  WIDTH  registered result; held until the next completion.

Behaviour:
- Reset (async, any state): state IDLE; acc=0, rem=0, result=0, done=0, busy=0, ready=1.
- States are IDLE, SHIFT and DONE.
- IDLE: ready=1. On a clk edge with start=1, the block captures din into acc, shamt into rem, and sh into op.
  - If bypass=1 or shamt=0, next state is DONE.
  - Otherwise next state is SHIFT.
- SHIFT: busy=1, ready=0.
  - Each edge: n = min(rem, STEP); acc <= op(acc, n); rem <= rem - n.
  - When rem - n == 0: next state is DONE, and result is loaded with the shifted acc on the same edge.
- DONE: done=1 for exactly one cycle, ready=0; next state is IDLE unconditionally. On the bypass/shamt=0 path, result is loaded with din on entry to DONE.
- Per-step ops, all WIDTH-bit with no carry out:
  - LSL: zero fill at the LSB end.
  - LSR: zero fill at the MSB end.
  - ASR: MSB end filled with acc[WIDTH-1], repeated each step, so the original sign is preserved.
  - ROR: bits leaving bit 0 re-enter at bit WIDTH-1.
  - The cumulative result equals the single-shot shift by shamt.
- Latency: with start high in cycle k, done is high in cycle k+1+ceil(shamt/STEP). For shamt=0 or bypass, done is high in cycle k+1.
- Busy is high for exactly ceil(shamt/STEP) cycles.
- Inputs (start, bypass, sh, shamt, din) are ignored outside IDLE. Changing them mid-operation has no effect.
- A start held high during SHIFT/DONE is not queued. It is accepted in the first IDLE cycle where it is still high, so back-to-back requests have a 1-cycle gap after done.
- result changes only on entry to DONE and is stable otherwise, including while the next operation is in SHIFT.
- Reset asserted mid-SHIFT aborts immediately: no done pulse, and result clears to 0.
- done and busy are never high together; ready = (state==IDLE).

Test Plan:
1. Assert reset, then release -> result=0x00000000, done=0, busy=0, ready=1; no done pulse for 5 idle cycles.
2. STEP=4, start with sh=00, shamt=31, din=0x00000001 -> busy high 8 cycles, done in cycle k+9, result=0x80000000.
3. sh=10, shamt=4, din=0x800000F0 -> 1 SHIFT cycle, done in cycle k+2, result=0xF800000F. Repeat with sh=01 -> 0x0800000F.
4. sh=11, shamt=8, din=0x12345678 -> 2 SHIFT cycles, result=0x78123456. Then back-to-back start held high with sh=01, same din -> second request accepted in the IDLE cycle after done; result=0x00123456.
5. bypass=1, sh=00, shamt=5, din=0xDEADBEEF -> done in k+1, result=0xDEADBEEF, busy never high. bypass=0, shamt=0 -> same timing and value.
6. Start LSL shamt=16 on din=0x0000FFFF, then change din/sh mid-SHIFT -> result=0xFFFF0000. Restart the same operation and assert reset in the 2nd SHIFT cycle -> immediate IDLE, result=0, no done pulse.

Source files
------------

// File: rtl/shift_seq.sv
// Iterative barrel-free shifter: LSL/LSR/ASR/ROR by 0..31, at most STEP bits per cycle.
// Latency: done pulses 1 + ceil(shamt/STEP) cycles after accept (1 cycle for bypass or shamt=0).
// Handshake: ready only in IDLE; start outside IDLE is ignored and never queued.
module shift_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic             bypass,
  input  logic [1:0]       sh,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] STEP5 = 5'(STEP);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0] rot;
  logic [4:0]         rem;
  logic [4:0]         rem_nxt;
  logic [4:0]         n;
  logic [1:0]         op;
  logic               skip;

  // A request that needs no shifting goes straight to DONE with din as the result.
  assign skip = bypass || (shamt == 5'd0);

  // One iteration: shift acc by n = min(rem, STEP) using the captured shift type.
  always_comb begin
    n        = (rem < STEP5) ? rem : STEP5;
    rem_nxt  = rem - n;
    rot      = {acc, acc} >> n;
    acc_step = acc;
    case (op)
      2'b00:   acc_step = acc << n;
      2'b01:   acc_step = acc >> n;
      2'b10:   acc_step = $signed(acc) >>> n;
      default: acc_step = rot[WIDTH-1:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs; all status flags decode directly from state.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = skip ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (rem_nxt == 5'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in SHIFT, load result only on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      rem    <= '0;
      op     <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= din;
            rem <= shamt;
            op  <= sh;
            if (skip) begin
              result <= din;
            end
          end
        end
        SHIFT: begin
          acc <= acc_step;
          rem <= rem_nxt;
          if (rem_nxt == 5'd0) begin
            result <= acc_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: directed requests push expected result/cycle/busy-count,
// a monitor pops on each done pulse and also watches for spurious done and result drift.
// Inputs driven on the falling edge; outputs sampled 1 time unit after the rising edge.
module tb_shift_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ready;
  logic        bypass;
  logic [1:0]  sh;
  logic [4:0]  shamt;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          nbusy;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          busy_cnt = 0;
  logic [31:0] last_res = 32'h0;

  shift_seq #(.WIDTH(32), .STEP(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ready  (ready),
    .bypass (bypass),
    .sh     (sh),
    .shamt  (shamt),
    .din    (din),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: value seen after rising edge e is e.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on done, checks timing, busy length and result hold.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      last_res = 32'h0;
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      chk("busy_and_done", {31'b0, busy && done}, 32'h0);
      if (busy) chk("result_hold", result, last_res);
      if (q.size() == 0) begin
        chk("spurious_done", {31'b0, done}, 32'h0);
      end else if (done) begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_cycle"}, cyc, e.cyc);
        chk({e.name, "_busy"}, busy_cnt, e.nbusy);
        last_res = e.res;
        busy_cnt = 0;
      end
      if (ready) busy_cnt = 0;
    end
  end

  task automatic issue(input logic bp, input logic [1:0] s, input logic [4:0] a,
                       input logic [31:0] d, input logic [31:0] er, input int nb,
                       input string nm);
    exp_t e;
    @(negedge clk);
    chk({nm, "_ready"}, {31'b0, ready}, 32'h1);
    bypass = bp; sh = s; shamt = a; din = d; start = 1'b1;
    e.res = er; e.cyc = cyc + 1 + nb; e.nbusy = nb; e.name = nm;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    chk("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   k;
    reset = 1'b1; start = 1'b0; bypass = 1'b0; sh = 2'b00; shamt = 5'd0; din = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h1);
    repeat (5) @(negedge clk);

    issue(1'b0, 2'b00, 5'd31, 32'h00000001, 32'h80000000, 8, "lsl31"); drain();
    issue(1'b0, 2'b10, 5'd4,  32'h800000F0, 32'hF800000F, 1, "asr4");  drain();
    issue(1'b0, 2'b01, 5'd4,  32'h800000F0, 32'h0800000F, 1, "lsr4");  drain();
    issue(1'b0, 2'b10, 5'd31, 32'h80000000, 32'hFFFFFFFF, 8, "asr31"); drain();
    issue(1'b0, 2'b11, 5'd5,  32'h00000001, 32'h08000000, 2, "ror5");  drain();
    issue(1'b0, 2'b01, 5'd3,  32'h000000F0, 32'h0000001E, 1, "lsr3");  drain();
    issue(1'b0, 2'b11, 5'd8,  32'h12345678, 32'h78123456, 2, "ror8");  drain();

    // Back-to-back: start held high; second request taken in the IDLE cycle after done.
    @(negedge clk);
    bypass = 1'b0; sh = 2'b11; shamt = 5'd8; din = 32'h12345678; start = 1'b1;
    k = cyc;
    e.res = 32'h78123456; e.cyc = k + 3; e.nbusy = 2; e.name = "b2b_ror"; q.push_back(e);
    e.res = 32'h00123456; e.cyc = k + 7; e.nbusy = 2; e.name = "b2b_lsr"; q.push_back(e);
    @(negedge clk);
    sh = 2'b01;
    repeat (4) @(negedge clk);
    start = 1'b0;
    drain();

    issue(1'b1, 2'b00, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 0, "bypass"); drain();
    issue(1'b0, 2'b00, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 0, "shamt0"); drain();

    // Inputs changed mid-SHIFT must not disturb the operation.
    issue(1'b0, 2'b00, 5'd16, 32'h0000FFFF, 32'hFFFF0000, 4, "lsl16");
    din = 32'hAAAA5555; sh = 2'b01; shamt = 5'd3;
    drain();

    // Reset in the second SHIFT cycle aborts with no done pulse and clears result.
    @(negedge clk);
    bypass = 1'b0; sh = 2'b00; shamt = 5'd16; din = 32'h0000FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_ready", {31'b0, ready}, 32'h1);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_abort_result", result, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
